// File: rtl/serial_addsub_pkg.sv
// Shared types and constants for the bit-serial adder/subtractor.
package serial_addsub_pkg;

    // Operand width used when the parent does not override WIDTH.
    localparam int DEFAULT_WIDTH = 8;

    // Control states: wait for start, shift WIDTH bits, present the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter value on the edge that processes the most significant bit.
    function automatic int last_count(input int width);
        return width - 1;
    endfunction

endpackage

// File: rtl/fas.sv
// 1-bit full adder / full subtractor cell.
// a_ns=1: s = a + b + cin, cout = carry out.
// a_ns=0: s = a - b - cin, cout = borrow out.
module fas (
    input  logic a,
    input  logic b,
    input  logic cin,
    input  logic a_ns,
    output logic s,
    output logic cout
);

    logic carry_s;
    logic borrow_s;

    // Sum/difference bit is the same XOR in both modes; only the carry term differs.
    always_comb begin
        s        = a ^ b ^ cin;
        carry_s  = (a & b) | (cin & (a ^ b));
        borrow_s = (~a & (b | cin)) | (b & cin);
        if (a_ns) begin
            cout = carry_s;
        end else begin
            cout = borrow_s;
        end
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one bit per clock, LSB first, through a single
// fas cell. IDLE -> RUN (WIDTH cycles) -> DONE (one cycle) -> IDLE.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             a_ns,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    localparam int             CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(last_count(WIDTH));

    state_e             state_q,  state_d;
    logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
    logic [WIDTH-1:0]   res_sh_q, res_sh_d;
    logic               mode_q,   mode_d;
    logic               carry_q,  carry_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q,   cout_d;

    logic               cell_s;
    logic               cell_c;
    logic               last_bit_s;

    // The one and only arithmetic cell; it sees the current LSBs and carry.
    fas u_fas (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .a_ns (mode_q),
        .s    (cell_s),
        .cout (cell_c)
    );

    assign last_bit_s = (cnt_q == CNT_LAST);

    // Next-state logic: start is only looked at in IDLE; DONE always returns to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (last_bit_s) begin
                    state_d = DONE;
                end else begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath next values: load operands on start, shift one bit per RUN cycle,
    // capture the final result and carry/borrow on the last bit.
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        mode_d   = mode_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        cout_d   = cout_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    res_sh_d = {WIDTH{1'b0}};
                    mode_d   = a_ns;
                    carry_d  = 1'b0;
                    cnt_d    = {CNT_W{1'b0}};
                end else begin
                    cnt_d    = cnt_q;
                end
            end
            RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                res_sh_d = {cell_s, res_sh_q[WIDTH-1:1]};
                carry_d  = cell_c;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last_bit_s) begin
                    result_d = {cell_s, res_sh_q[WIDTH-1:1]};
                    cout_d   = cell_c;
                end else begin
                    result_d = result_q;
                end
            end
            DONE: begin
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // Status flags are decoded from the next state so they are registered
    // and line up exactly with the state they describe.
    always_comb begin
        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    // All state of the block; reset aborts any operation without a done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= {WIDTH{1'b0}};
            b_sh_q   <= {WIDTH{1'b0}};
            res_sh_q <= {WIDTH{1'b0}};
            mode_q   <= 1'b0;
            carry_q  <= 1'b0;
            cnt_q    <= {CNT_W{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= {WIDTH{1'b0}};
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            mode_q   <= mode_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            cout_q   <= cout_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed bench for serial_addsub at WIDTH=8.
module tb_serial_addsub;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         a_ns;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vm;
        logic [W-1:0] er;
        logic         ec;
    } vec_t;

    vec_t vecs [8];

    serial_addsub #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .a_ns   (a_ns),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; drives one start and checks latency and result.
    task automatic run_op(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vm,
                          input logic [W-1:0] er, input logic ec, input string name);
        int k;
        bit seen;
        a = va; b = vb; a_ns = vm; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = ~va; b = ~vb; a_ns = ~vm;
        k = 1;
        seen = 1'b0;
        while (!seen && k <= 20) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (k == 1) check({name, "_busy"}, {31'd0, busy}, 32'd1);
                @(negedge clk);
                k++;
            end
        end
        check({name, "_latency"}, k, 32'd9);
        check({name, "_result"}, {24'd0, result}, {24'd0, er});
        check({name, "_cout"}, {31'd0, cout}, {31'd0, ec});
        check({name, "_busy_done"}, {31'd0, busy}, 32'd0);
        @(negedge clk);
        check({name, "_done_1cyc"}, {31'd0, done}, 32'd0);
        check({name, "_hold"}, {23'd0, cout, result}, {23'd0, ec, er});
    endtask

    initial begin : main
        int dcount;
        int last_done;
        logic [W-1:0] bb_a [3];
        logic [W-1:0] bb_b [3];
        logic         bb_m [3];
        logic [W-1:0] bb_r [3];
        logic         bb_c [3];

        vecs[0] = '{8'h35, 8'h4A, 1'b1, 8'h7F, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b1, 8'h00, 1'b1};
        vecs[2] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1};
        vecs[3] = '{8'h20, 8'h20, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b1, 8'h00, 1'b1};
        vecs[5] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[6] = '{8'hA5, 8'h5A, 1'b1, 8'hFF, 1'b0};
        vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0};

        rst_n = 1'b1; start = 1'b0; a = '0; b = '0; a_ns = 1'b0;
        #5 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", {21'd0, busy, done, cout, result}, 32'd0);

        // First start is offered on the very cycle reset is released.
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].va, vecs[i].vb, vecs[i].vm, vecs[i].er, vecs[i].ec,
                   $sformatf("vec%0d", i));
        end

        // Second start pulsed during RUN must be ignored.
        a = 8'h12; b = 8'h34; a_ns = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dcount = 0;
        for (int k = 1; k <= 25; k++) begin
            if (k == 3) begin
                start = 1'b1; a = 8'hFF; b = 8'hFF; a_ns = 1'b0;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                dcount++;
                check("ignore_latency", k, 32'd9);
                check("ignore_result", {23'd0, cout, result}, {23'd0, 1'b0, 8'h46});
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("ignore_done_count", dcount, 32'd1);
        check("ignore_hold", {24'd0, result}, 32'h46);

        // Reset in the 4th RUN cycle aborts the operation.
        a = 8'h55; b = 8'h33; a_ns = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("abort_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {21'd0, busy, done, cout, result}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dcount = 0;
        for (int k = 0; k < 15; k++) begin
            if (done) dcount++;
            @(negedge clk);
        end
        check("abort_no_done", dcount, 32'd0);
        run_op(8'h01, 8'h01, 1'b1, 8'h02, 1'b0, "after_abort");

        // start held high: three operations back to back.
        bb_a = '{8'h01, 8'hF0, 8'h05};
        bb_b = '{8'h02, 8'h20, 8'h07};
        bb_m = '{1'b1,  1'b1,  1'b0};
        bb_r = '{8'h03, 8'h10, 8'hFE};
        bb_c = '{1'b0,  1'b1,  1'b1};
        a = bb_a[0]; b = bb_b[0]; a_ns = bb_m[0]; start = 1'b1;
        @(negedge clk);
        dcount = 0;
        last_done = 0;
        for (int k = 1; k <= 60 && dcount < 3; k++) begin
            if (done) begin
                check($sformatf("b2b%0d_result", dcount), {23'd0, cout, result},
                      {23'd0, bb_c[dcount], bb_r[dcount]});
                if (dcount == 0) check("b2b0_latency", k, 32'd9);
                else check($sformatf("b2b%0d_spacing", dcount), k - last_done, 32'd10);
                last_done = k;
                dcount++;
                if (dcount < 3) begin
                    a = bb_a[dcount]; b = bb_b[dcount]; a_ns = bb_m[dcount];
                end else begin
                    start = 1'b0;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("b2b_done_count", dcount, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
